// File: rtl/z16_pkg.sv
// rtl/z16_pkg.sv - shared constants and types for the Z16 MMIO GPIO peripheral
package z16_pkg;

  localparam logic [15:0] GPIO_BASE = 16'h0078;

  localparam int unsigned GPIO_OFS_IRQ_EN = 0;
  localparam int unsigned GPIO_OFS_OUT    = 2;
  localparam int unsigned GPIO_OFS_IN     = 4;
  localparam int unsigned GPIO_OFS_EDGE   = 6;

  typedef enum logic [1:0] {
    GPIO_REG_IRQ_EN,
    GPIO_REG_OUT,
    GPIO_REG_IN,
    GPIO_REG_EDGE
  } gpio_reg_e;

endpackage

// File: rtl/z16_debounce.sv
// rtl/z16_debounce.sv - single-channel two-flop synchroniser and debounce counter
module z16_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_stable,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // accept is the cycle in which stable flips; exported so EDGE can set on that same posedge
  assign accept   = (sync_q[1] != stable_q) && (cnt_q == CNT_LAST);
  assign o_rise   = accept & sync_q[1];
  assign o_stable = stable_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], i_pin};
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/z16_mmio_gpio.sv
// rtl/z16_mmio_gpio.sv - memory-mapped GPIO: output register, debounced inputs, edge flags, irq
module z16_mmio_gpio
  import z16_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(GPIO_BASE),
  parameter int unsigned N_OUT           = 6,
  parameter int unsigned N_IN            = 1,
  parameter logic [N_IN-1:0] IN_POLARITY = '0,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_hit,
  input  logic [N_IN-1:0]   i_in,
  output logic [N_OUT-1:0]  o_out,
  output logic              o_irq
);

  localparam logic [ADDR_W-1:0] A_IRQ_EN = BASE_ADDR + ADDR_W'(GPIO_OFS_IRQ_EN);
  localparam logic [ADDR_W-1:0] A_OUT    = BASE_ADDR + ADDR_W'(GPIO_OFS_OUT);
  localparam logic [ADDR_W-1:0] A_IN     = BASE_ADDR + ADDR_W'(GPIO_OFS_IN);
  localparam logic [ADDR_W-1:0] A_EDGE   = BASE_ADDR + ADDR_W'(GPIO_OFS_EDGE);

  gpio_reg_e        sel;
  logic [N_IN-1:0]  irq_en_q;
  logic [N_OUT-1:0] out_q;
  logic [N_IN-1:0]  edge_q;
  logic [N_IN-1:0]  in_stable;
  logic [N_IN-1:0]  in_rise;
  logic [N_IN-1:0]  edge_clr;
  logic             wr_en;
  logic             wdata_unused;

  assign wdata_unused = ^i_wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    z16_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_pin   (i_in[i] ^ IN_POLARITY[i]),
      .o_stable(in_stable[i]),
      .o_rise  (in_rise[i])
    );
  end

  always_comb begin
    o_hit = 1'b1;
    sel   = GPIO_REG_IRQ_EN;
    case (i_addr)
      A_IRQ_EN: sel = GPIO_REG_IRQ_EN;
      A_OUT:    sel = GPIO_REG_OUT;
      A_IN:     sel = GPIO_REG_IN;
      A_EDGE:   sel = GPIO_REG_EDGE;
      default:  o_hit = 1'b0;
    endcase
  end

  always_comb begin
    o_rdata = '0;
    if (o_hit) begin
      case (sel)
        GPIO_REG_IRQ_EN: o_rdata[N_IN-1:0]  = irq_en_q;
        GPIO_REG_OUT:    o_rdata[N_OUT-1:0] = out_q;
        GPIO_REG_IN:     o_rdata[N_IN-1:0]  = in_stable;
        GPIO_REG_EDGE:   o_rdata[N_IN-1:0]  = edge_q;
        default:         o_rdata = '0;
      endcase
    end
  end

  assign wr_en    = i_wen && o_hit;
  assign edge_clr = (wr_en && sel == GPIO_REG_EDGE) ? i_wdata[N_IN-1:0] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_en_q <= '0;
      out_q    <= '0;
      edge_q   <= '0;
    end else begin
      if (wr_en && sel == GPIO_REG_IRQ_EN) irq_en_q <= i_wdata[N_IN-1:0];
      if (wr_en && sel == GPIO_REG_OUT)    out_q    <= i_wdata[N_OUT-1:0];
      // set is applied after the clear so a coincident rising edge is never lost
      edge_q <= (edge_q & ~edge_clr) | in_rise;
    end
  end

  assign o_out = out_q;
  assign o_irq = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_z16_mmio_gpio.sv
// tb/tb_z16_mmio_gpio.sv - scoreboard-driven self-checking bench for z16_mmio_gpio
module tb_z16_mmio_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata;
  logic        wen;
  logic [15:0] rdata, rdata_p;
  logic        hit, hit_p;
  logic [1:0]  pin, pin_p;
  logic [5:0]  out, out_p;
  logic        irq, irq_p;

  always #5 clk = ~clk;

  z16_mmio_gpio #(
    .N_OUT(6), .N_IN(2), .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wen(wen), .i_wdata(wdata),
    .o_rdata(rdata), .o_hit(hit), .i_in(pin), .o_out(out), .o_irq(irq)
  );

  z16_mmio_gpio #(
    .N_OUT(6), .N_IN(2), .IN_POLARITY(2'b01), .DEBOUNCE_CYCLES(4)
  ) u_pol (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wen(wen), .i_wdata(wdata),
    .o_rdata(rdata_p), .o_hit(hit_p), .i_in(pin_p), .o_out(out_p), .o_irq(irq_p)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow got=0x%0h exp=none", got);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string tag, input logic [31:0] got, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_check(got);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp, input logic exp_hit);
    wen  = 1'b0;
    addr = a;
    sb_push({tag, "_data"}, 32'(exp));
    sb_push({tag, "_hit"}, 32'(exp_hit));
    #1;
    sb_check(32'(rdata));
    sb_check(32'(hit));
  endtask

  task automatic rd_pol(input string tag, input logic [15:0] a, input logic [15:0] exp);
    wen  = 1'b0;
    addr = a;
    sb_push(tag, 32'(exp));
    #1;
    sb_check(32'(rdata_p));
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  // the load in the clearing cycle must still see the pre-clear flags
  task automatic w1c_edge(input string tag, input logic [15:0] mask, input logic [15:0] exp_pre);
    addr  = 16'h007E;
    wdata = mask;
    wen   = 1'b1;
    sb_push(tag, 32'(exp_pre));
    #1;
    sb_check(32'(rdata));
    tick();
    wen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pin = 2'b00; pin_p = 2'b00;
    addr = '0; wdata = '0; wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    expect_now("rst_out", 32'(out), 32'h0);
    expect_now("rst_irq", 32'(irq), 32'h0);
    rd("rst_in", 16'h007C, 16'h0000, 1'b1);
    rd("rst_nohit", 16'h0080, 16'h0000, 1'b0);
    rd_pol("rst_pol_in", 16'h007C, 16'h0000);
    rst = 1'b0;

    wr(16'h007A, 16'hFFEA);
    expect_now("out_commit", 32'(out), 32'h2A);
    rd("out_read", 16'h007A, 16'h002A, 1'b1);
    wr(16'h007C, 16'h1234);
    rd("in_ro", 16'h007C, 16'h0000, 1'b1);

    pin[0] = 1'b1;
    repeat (3) tick();
    pin[0] = 1'b0;
    repeat (8) begin
      tick();
      rd("glitch_in", 16'h007C, 16'h0000, 1'b1);
    end
    rd("glitch_edge", 16'h007E, 16'h0000, 1'b1);

    pin[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd($sformatf("hold_in_e%0d", k), 16'h007C, (k == 6) ? 16'h0001 : 16'h0000, 1'b1);
      rd($sformatf("hold_edge_e%0d", k), 16'h007E, (k == 6) ? 16'h0001 : 16'h0000, 1'b1);
    end

    pin[0] = 1'b0;
    repeat (8) tick();
    rd("release_in", 16'h007C, 16'h0000, 1'b1);
    rd("release_edge", 16'h007E, 16'h0001, 1'b1);
    expect_now("release_irq", 32'(irq), 32'h0);

    wr(16'h0078, 16'h0001);
    expect_now("irq_en_irq", 32'(irq), 32'h1);
    rd("irq_en_read", 16'h0078, 16'h0001, 1'b1);
    w1c_edge("w1c_pre", 16'h0001, 16'h0001);
    expect_now("w1c_irq", 32'(irq), 32'h0);
    rd("w1c_edge", 16'h007E, 16'h0000, 1'b1);

    pin[0] = 1'b1;
    repeat (5) tick();
    w1c_edge("coll_pre", 16'h0001, 16'h0000);
    rd("coll_edge", 16'h007E, 16'h0001, 1'b1);
    expect_now("coll_irq", 32'(irq), 32'h1);
    w1c_edge("coll_clr_pre", 16'h0001, 16'h0001);
    rd("coll_clr_edge", 16'h007E, 16'h0000, 1'b1);

    pin[1] = 1'b1;
    repeat (8) tick();
    rd("ch1_edge", 16'h007E, 16'h0002, 1'b1);
    rd("ch1_in", 16'h007C, 16'h0003, 1'b1);
    expect_now("ch1_masked_irq", 32'(irq), 32'h0);

    wr(16'h0078, 16'h0003);
    expect_now("pre_rst_irq", 32'(irq), 32'h1);
    wr(16'h007A, 16'h0015);
    expect_now("pre_rst_out", 32'(out), 32'h15);
    pin[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    expect_now("arst_out", 32'(out), 32'h0);
    expect_now("arst_irq", 32'(irq), 32'h0);
    rd("arst_edge", 16'h007E, 16'h0000, 1'b1);
    rd("arst_in", 16'h007C, 16'h0000, 1'b1);
    rd("arst_irq_en", 16'h0078, 16'h0000, 1'b1);
    rst = 1'b0;
    pin[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd($sformatf("post_rst_in_e%0d", k), 16'h007C, (k == 6) ? 16'h0003 : 16'h0000, 1'b1);
      rd_pol($sformatf("pol_in_e%0d", k), 16'h007C, (k == 6) ? 16'h0001 : 16'h0000);
    end
    rd_pol("pol_edge", 16'h007E, 16'h0001);
    expect_now("pol_irq", 32'(irq_p), 32'h0);
    expect_now("pol_out", 32'(out_p), 32'h0);
    expect_now("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
